disp_timing_pixout: RTL and testbench
=====================================

// Module: disp_timing_pixout
// PURPOSE
//  Display-clock back end of the display circuit. Generates VGA/XGA/SXGA raster timing,
//  pops 64-bit two-pixel words from the pixel FIFO (ACLK->DCLK FIFO, DCLK read side),
//  unpacks them to 24-bit RGB and drives DSP_R/G/B, DSP_DE, DSP_HSYNC_X, DSP_VSYNC_X.
//  Also flags FIFO underflow and emits a VBLANK pulse for the register block.
// PARAMETERS
//  P_PIPE   2  latency (DCLK) from raster counters to DSP_* outputs; fixed design value, not tunable
// PORTS
//  DCLK            in   1   display pixel clock (25.175/65/108 MHz per resolution)
//  DRST            in   1   asynchronous, active-high reset
//  RESOL           in   2   00=VGA 01=XGA 10=SXGA 11=treated as VGA; quasi-static
//  DISPON          in   1   display enable (synchronised upstream)
//  UNDER_CLR       in   1   one-cycle pulse, clears DSP_FIFO_UNDER
//  FIFO_DOUT       in   64  [23:0]=pixel0 {R,G,B}, [55:32]=pixel1 {R,G,B}, others ignored
//  FIFO_EMPTY      in   1   FIFO empty
//  FIFO_RDEN       out  1   FIFO pop; data valid on FIFO_DOUT the following DCLK
//  DSP_R/G/B       out  8 each  pixel colour
//  DSP_DE          out  1   active-video enable
//  DSP_HSYNC_X     out  1   horizontal sync, active low
//  DSP_VSYNC_X     out  1   vertical sync, active low
//  DSP_FIFO_UNDER  out  1   sticky underflow flag
//  VBLANK_PULSE    out  1   one-DCLK pulse at start of vertical blanking
// BEHAVIOUR
//  Timing table (HACT,HFP,HSW,HBP / VACT,VFP,VSW,VBP); HTOT/VTOT are sums:
//   VGA  640,16,96,48 (800)  / 480,10,2,33 (525)
//   XGA  1024,24,136,160 (1344) / 768,3,6,29 (806)
//   SXGA 1280,48,112,248 (1688) / 1024,1,3,38 (1066)
//  Counters: HCNT 0..HTOT-1 (11b), VCNT 0..VTOT-1 (11b); VCNT increments when HCNT wraps.
//  Active region HCNT<HACT && VCNT<VACT. HSYNC when HACT+HFP <= HCNT < HACT+HFP+HSW;
//  VSYNC likewise on VCNT (whole lines).
//  Resolution register: loaded from RESOL only on last pixel of frame
//   (HCNT=HTOT-1 && VCNT=VTOT-1); mid-frame RESOL changes have no effect until then.
//  Stage0 (counter cycle): preDE, preHS, preVS computed.
//   FIFO_RDEN = preDE & DISPON & HCNT[0]==0 & ~FIFO_EMPTY.
//  Stage1: FIFO_DOUT valid for an even-pixel pop; the word is held in a 64b register.
//   Odd pixel uses the held word's [55:32].
//  Stage2: registered outputs. DSP_* lag stage0 by exactly P_PIPE=2 DCLK; syncs and DE
//   are delayed identically, so DE/HS/VS alignment equals the table.
//  Underflow: even pixel in active region, DISPON=1, FIFO_EMPTY=1 -> no pop; both pixels
//   of that pair output 000000; DSP_FIFO_UNDER set. It stays set until UNDER_CLR;
//   if set and clear happen in the same cycle, set wins.
//  DISPON=0: timing, DE and syncs keep running; no pops; RGB=000000.
//   DISPON changes take effect at the next even pixel only (no half-pair output).
//  Outside DE, RGB=000000.
//  VBLANK_PULSE: 1 for one DCLK when HCNT=0 && VCNT=VACT (stage0 timing, not delayed).
//  Reset (DRST=1, async): HCNT=VCNT=0, resolution=VGA, pipeline cleared.
//   Outputs: FIFO_RDEN=0, DSP_R/G/B=0, DSP_DE=0, DSP_HSYNC_X=1, DSP_VSYNC_X=1,
//   DSP_FIFO_UNDER=0, VBLANK_PULSE=0.
//   First frame after reset is VGA; RESOL is applied from the following frame.
//  Reset mid-line: all state abandoned, no further pops; FIFO flush is the FIFO owner's job.
// TESTING
//  1 Reset, RESOL=01, DISPON=0: frame 1 HSYNC period 800 DCLK; from frame 2: 1344 DCLK,
//    HSYNC_X low 136 DCLK, DE high 1024/line, 768 lines, VSYNC_X low 6 lines.
//  2 XGA, DISPON=1, FIFO model returns {8'h0,24'h112233,8'h0,24'h445566} per pop:
//    512 pops/line; DSP RGB alternates 445566 (pixel0), 112233 (pixel1); first DE
//    edge exactly 2 DCLK after HCNT=0.
//  3 Force FIFO_EMPTY for one even pixel mid-line: that pair outputs 000000,
//    DSP_FIFO_UNDER=1 and stays 1; pulse UNDER_CLR -> 0. Same-cycle set+clear -> stays 1.
//  4 Switch RESOL 01->10 mid-frame: current frame finishes at 1344x806; next frame
//    1688x1066 with 1280 DE per line.
//  5 VBLANK_PULSE: exactly one pulse per frame at VCNT=768, HCNT=0 (XGA);
//    period 1344*806 DCLK.
//  6 Assert DRST mid-active-line: outputs go to reset values immediately
//    (asynchronous), FIFO_RDEN=0; after release, timing restarts at HCNT=0, VCNT=0.

Source files
------------

// File: rtl/disp_timing_pixout_if.sv
// Pixel-FIFO read side, register-block handshakes and display output bus of disp_timing_pixout.
// master = FIFO/register side driving the block, slave = the display back end itself.
interface disp_timing_pixout_if;
  logic [1:0]  RESOL;
  logic        DISPON;
  logic        UNDER_CLR;
  logic [63:0] FIFO_DOUT;
  logic        FIFO_EMPTY;
  logic        FIFO_RDEN;
  logic [7:0]  DSP_R;
  logic [7:0]  DSP_G;
  logic [7:0]  DSP_B;
  logic        DSP_DE;
  logic        DSP_HSYNC_X;
  logic        DSP_VSYNC_X;
  logic        DSP_FIFO_UNDER;
  logic        VBLANK_PULSE;

  modport master (
    output RESOL, DISPON, UNDER_CLR, FIFO_DOUT, FIFO_EMPTY,
    input  FIFO_RDEN, DSP_R, DSP_G, DSP_B, DSP_DE, DSP_HSYNC_X, DSP_VSYNC_X,
           DSP_FIFO_UNDER, VBLANK_PULSE
  );

  modport slave (
    input  RESOL, DISPON, UNDER_CLR, FIFO_DOUT, FIFO_EMPTY,
    output FIFO_RDEN, DSP_R, DSP_G, DSP_B, DSP_DE, DSP_HSYNC_X, DSP_VSYNC_X,
           DSP_FIFO_UNDER, VBLANK_PULSE
  );
endinterface

// File: rtl/disp_timing_pixout.sv
// VGA/XGA/SXGA raster generator and two-pixel FIFO unpacker; DSP_* lag the raster counters by 2 DCLK.
// Never stalls: an empty FIFO at an even active pixel blanks that pixel pair and sets a sticky flag.
module disp_timing_pixout (
  input  logic                DCLK,
  input  logic                DRST,
  disp_timing_pixout_if.slave bus
);
  localparam int P_PIPE = 2;

  typedef enum logic [1:0] {
    RES_VGA  = 2'b00,
    RES_XGA  = 2'b01,
    RES_SXGA = 2'b10
  } res_e;

  res_e        res_q;
  logic [10:0] hcnt;
  logic [10:0] vcnt;

  logic [10:0] hact, hfp, hsw, hbp, htot;
  logic [10:0] vact, vfp, vsw, vbp, vtot;
  logic [10:0] hs_beg, hs_end, vs_beg, vs_end;
  logic        h_last, v_last;

  logic        pre_de, pre_hs, pre_vs;
  logic        pix_even, pair_req, pop, under_set;

  logic [P_PIPE-1:0] de_sr, hs_sr, vs_sr;
  logic        s1_even, s1_pop;
  logic        pair_ok_q;
  logic [23:0] word_hi_q;
  logic [23:0] pix_rgb;
  logic [23:0] rgb_q;
  logic        under_q;
  logic        unused_dout;

  always_comb begin
    case (res_q)
      RES_XGA: begin
        hact = 11'd1024; hfp = 11'd24; hsw = 11'd136; hbp = 11'd160;
        vact = 11'd768;  vfp = 11'd3;  vsw = 11'd6;   vbp = 11'd29;
      end
      RES_SXGA: begin
        hact = 11'd1280; hfp = 11'd48; hsw = 11'd112; hbp = 11'd248;
        vact = 11'd1024; vfp = 11'd1;  vsw = 11'd3;   vbp = 11'd38;
      end
      default: begin
        hact = 11'd640;  hfp = 11'd16; hsw = 11'd96;  hbp = 11'd48;
        vact = 11'd480;  vfp = 11'd10; vsw = 11'd2;   vbp = 11'd33;
      end
    endcase
  end

  assign htot   = hact + hfp + hsw + hbp;
  assign vtot   = vact + vfp + vsw + vbp;
  assign hs_beg = hact + hfp;
  assign hs_end = hs_beg + hsw;
  assign vs_beg = vact + vfp;
  assign vs_end = vs_beg + vsw;
  assign h_last = (hcnt == htot - 11'd1);
  assign v_last = (vcnt == vtot - 11'd1);

  // Resolution only changes on the last pixel of a frame, so a frame is never torn.
  always_ff @(posedge DCLK or posedge DRST) begin
    if (DRST) begin
      hcnt  <= '0;
      vcnt  <= '0;
      res_q <= RES_VGA;
    end else if (h_last) begin
      hcnt <= '0;
      if (v_last) begin
        vcnt  <= '0;
        res_q <= (bus.RESOL == 2'b11) ? RES_VGA : res_e'(bus.RESOL);
      end else begin
        vcnt <= vcnt + 11'd1;
      end
    end else begin
      hcnt <= hcnt + 11'd1;
    end
  end

  assign pre_de    = (hcnt < hact) && (vcnt < vact);
  assign pre_hs    = (hcnt >= hs_beg) && (hcnt < hs_end);
  assign pre_vs    = (vcnt >= vs_beg) && (vcnt < vs_end);
  assign pix_even  = ~hcnt[0];
  assign pair_req  = pre_de & bus.DISPON & pix_even;
  assign pop       = pair_req & ~bus.FIFO_EMPTY;
  assign under_set = pair_req & bus.FIFO_EMPTY;

  assign bus.FIFO_RDEN    = pop & ~DRST;
  assign bus.VBLANK_PULSE = (hcnt == 11'd0) && (vcnt == vact);

  // Even pixel takes the live FIFO word; the odd pixel replays the upper half of that same pop.
  always_comb begin
    pix_rgb = 24'h0;
    if (s1_even) begin
      if (s1_pop) pix_rgb = bus.FIFO_DOUT[23:0];
    end else if (de_sr[0] && pair_ok_q) begin
      pix_rgb = word_hi_q;
    end
  end

  always_ff @(posedge DCLK or posedge DRST) begin
    if (DRST) begin
      de_sr     <= '0;
      hs_sr     <= '0;
      vs_sr     <= '0;
      s1_even   <= 1'b0;
      s1_pop    <= 1'b0;
      pair_ok_q <= 1'b0;
      word_hi_q <= '0;
      rgb_q     <= '0;
      under_q   <= 1'b0;
    end else begin
      de_sr   <= {de_sr[P_PIPE-2:0], pre_de};
      hs_sr   <= {hs_sr[P_PIPE-2:0], pre_hs};
      vs_sr   <= {vs_sr[P_PIPE-2:0], pre_vs};
      s1_even <= pix_even;
      s1_pop  <= pop;
      if (s1_even) begin
        pair_ok_q <= s1_pop;
        if (s1_pop) word_hi_q <= bus.FIFO_DOUT[55:32];
      end
      rgb_q <= pix_rgb;
      if (under_set) begin
        under_q <= 1'b1;
      end else if (bus.UNDER_CLR) begin
        under_q <= 1'b0;
      end
    end
  end

  assign bus.DSP_R          = rgb_q[23:16];
  assign bus.DSP_G          = rgb_q[15:8];
  assign bus.DSP_B          = rgb_q[7:0];
  assign bus.DSP_DE         = de_sr[P_PIPE-1];
  assign bus.DSP_HSYNC_X    = ~hs_sr[P_PIPE-1];
  assign bus.DSP_VSYNC_X    = ~vs_sr[P_PIPE-1];
  assign bus.DSP_FIFO_UNDER = under_q;

  assign unused_dout = ^{bus.FIFO_DOUT[63:56], bus.FIFO_DOUT[31:24]};
endmodule

// File: tb/tb_disp_timing_pixout.sv
// Bench for disp_timing_pixout: frame-index reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_disp_timing_pixout;
  logic DCLK = 1'b0;
  logic DRST;

  disp_timing_pixout_if bus ();
  disp_timing_pixout dut (.DCLK(DCLK), .DRST(DRST), .bus(bus));

  always #5 DCLK = ~DCLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  // Timing table indexed by resolution code 0=VGA 1=XGA 2=SXGA.
  int T_HACT [3] = '{640, 1024, 1280};
  int T_HFP  [3] = '{16, 24, 48};
  int T_HSW  [3] = '{96, 136, 112};
  int T_HBP  [3] = '{48, 160, 248};
  int T_VACT [3] = '{480, 768, 1024};
  int T_VFP  [3] = '{10, 3, 1};
  int T_VSW  [3] = '{2, 6, 3};
  int T_VBP  [3] = '{33, 29, 38};

  // Model: pixel g of the run belongs to pair g>>1; a pair shows data only if its pop happened.
  typedef struct { bit de; bit hs; bit vs; bit odd; longint key; } pix_t;
  pix_t        pq[$];
  pix_t        cur, old;
  logic [63:0] pair_word [longint];
  logic [63:0] w;
  logic [23:0] exp_rgb;
  longint      g, last_key;
  int          m_idx, m_res, m_h_next;
  int          ht, vt, h, v, hs0, vs0;
  bit          m_under, last_pop, de, hs, vs, req;

  always @(negedge DCLK) begin
    if (DRST !== 1'b0) begin
      chk("rst_rden", bus.FIFO_RDEN, 0);
      chk("rst_de", bus.DSP_DE, 0);
      chk("rst_hsync_x", bus.DSP_HSYNC_X, 1);
      chk("rst_vsync_x", bus.DSP_VSYNC_X, 1);
      chk("rst_rgb", {bus.DSP_R, bus.DSP_G, bus.DSP_B}, 0);
      chk("rst_under", bus.DSP_FIFO_UNDER, 0);
      chk("rst_vblank", bus.VBLANK_PULSE, 0);
      g = 0; m_idx = 0; m_res = 0; m_h_next = 0;
      m_under = 0; last_pop = 0; last_key = 0;
      pair_word.delete();
      pq.delete();
      cur.de = 0; cur.hs = 0; cur.vs = 0; cur.odd = 0; cur.key = -1;
      pq.push_back(cur);
      pq.push_back(cur);
    end else begin
      ht  = T_HACT[m_res] + T_HFP[m_res] + T_HSW[m_res] + T_HBP[m_res];
      vt  = T_VACT[m_res] + T_VFP[m_res] + T_VSW[m_res] + T_VBP[m_res];
      h   = m_idx % ht;
      v   = m_idx / ht;
      hs0 = T_HACT[m_res] + T_HFP[m_res];
      vs0 = T_VACT[m_res] + T_VFP[m_res];
      de  = (h < T_HACT[m_res]) && (v < T_VACT[m_res]);
      hs  = (h >= hs0) && (h < hs0 + T_HSW[m_res]);
      vs  = (v >= vs0) && (v < vs0 + T_VSW[m_res]);
      req = de && (bus.DISPON === 1'b1) && ((h % 2) == 0);

      if (last_pop) pair_word[last_key] = bus.FIFO_DOUT;

      chk("rden", bus.FIFO_RDEN, req && (bus.FIFO_EMPTY === 1'b0));
      chk("vblank", bus.VBLANK_PULSE, (h == 0) && (v == T_VACT[m_res]));
      chk("under_flag", bus.DSP_FIFO_UNDER, m_under);

      old = pq.pop_front();
      exp_rgb = 24'h0;
      if (old.de && pair_word.exists(old.key)) begin
        w = pair_word[old.key];
        exp_rgb = old.odd ? w[55:32] : w[23:0];
      end
      chk("dsp_de", bus.DSP_DE, old.de);
      chk("dsp_hsync_x", bus.DSP_HSYNC_X, !old.hs);
      chk("dsp_vsync_x", bus.DSP_VSYNC_X, !old.vs);
      chk("dsp_rgb", {bus.DSP_R, bus.DSP_G, bus.DSP_B}, exp_rgb);

      if (req && bus.FIFO_EMPTY) m_under = 1;
      else if (bus.UNDER_CLR) m_under = 0;

      last_pop = req && (bus.FIFO_EMPTY === 1'b0);
      last_key = g >> 1;
      cur.de = de; cur.hs = hs; cur.vs = vs; cur.odd = (h % 2) != 0; cur.key = g >> 1;
      pq.push_back(cur);
      g++;
      m_idx++;
      if (m_idx == ht * vt) begin
        m_idx = 0;
        m_res = (bus.RESOL == 2'd3) ? 0 : int'(bus.RESOL);
      end
      m_h_next = m_idx % (T_HACT[m_res] + T_HFP[m_res] + T_HSW[m_res] + T_HBP[m_res]);
    end
  end

  task automatic tick();
    @(posedge DCLK);
    #1;
  endtask

  // Returns just after the edge that puts the DUT's horizontal counter at target.
  task automatic wait_h(input int target);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (m_h_next != target && n < 2000);
    if (n >= 2000) timeout_fail("wait_h");
  endtask

  task automatic first_de(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.DSP_DE !== 1'b1 && n < 50);
  endtask

  task automatic measure_line(output int period, output int low_w, output int de_cnt);
    logic prev;
    int   n;
    period = 0; low_w = 0; de_cnt = 0; n = 0;
    prev = bus.DSP_HSYNC_X;
    forever begin
      tick();
      n++;
      if (prev === 1'b1 && bus.DSP_HSYNC_X === 1'b0) break;
      prev = bus.DSP_HSYNC_X;
      if (n > 2000) break;
    end
    if (n > 2000) begin
      timeout_fail("hsync_edge");
      return;
    end
    forever begin
      period++;
      if (bus.DSP_HSYNC_X === 1'b0) low_w++;
      if (bus.DSP_DE === 1'b1) de_cnt++;
      prev = bus.DSP_HSYNC_X;
      tick();
      if (prev === 1'b1 && bus.DSP_HSYNC_X === 1'b0) break;
      if (period > 4000) break;
    end
  endtask

  initial begin
    int per, lw, dec, n, pops;
    DRST          = 1'b1;
    bus.RESOL     = 2'b01;
    bus.DISPON    = 1'b0;
    bus.UNDER_CLR = 1'b0;
    bus.FIFO_DOUT = '0;
    bus.FIFO_EMPTY = 1'b1;
    repeat (4) tick();
    chk("reset_de_lit", bus.DSP_DE, 0);
    chk("reset_hsync_lit", bus.DSP_HSYNC_X, 1);
    DRST = 1'b0;

    // First frame after reset is VGA even though XGA is requested.
    first_de(n);
    chk("first_de_latency", n, 2);
    measure_line(per, lw, dec);
    chk("vga_h_period", per, 800);
    chk("vga_hsync_low", lw, 96);
    chk("vga_de_per_line", dec, 640);
    chk("vga_vsync_idle", bus.DSP_VSYNC_X, 1);

    bus.FIFO_DOUT  = 64'h0011_2233_0044_5566;
    bus.FIFO_EMPTY = 1'b0;
    bus.DISPON     = 1'b1;
    bus.RESOL      = 2'b10;
    wait_h(0);
    pops = 0;
    for (int i = 0; i < 800; i++) begin
      if (bus.FIFO_RDEN === 1'b1) pops++;
      tick();
    end
    chk("pops_per_line", pops, 320);

    // Underflow on pair 100/101 with a clear in the same cycle: set wins.
    wait_h(100);
    bus.FIFO_EMPTY = 1'b1;
    bus.UNDER_CLR  = 1'b1;
    tick();
    bus.FIFO_EMPTY = 1'b0;
    bus.UNDER_CLR  = 1'b0;
    tick();
    chk("under_set_wins", bus.DSP_FIFO_UNDER, 1);
    chk("under_px0_black", {bus.DSP_R, bus.DSP_G, bus.DSP_B}, 24'h000000);
    tick();
    chk("under_px1_black", {bus.DSP_R, bus.DSP_G, bus.DSP_B}, 24'h000000);
    tick();
    chk("px0_445566", {bus.DSP_R, bus.DSP_G, bus.DSP_B}, 24'h445566);
    tick();
    chk("px1_112233", {bus.DSP_R, bus.DSP_G, bus.DSP_B}, 24'h112233);
    chk("under_sticky", bus.DSP_FIFO_UNDER, 1);
    wait_h(200);
    bus.UNDER_CLR = 1'b1;
    tick();
    bus.UNDER_CLR = 1'b0;
    chk("under_cleared", bus.DSP_FIFO_UNDER, 0);

    for (int i = 0; i < 30000; i++) begin
      bus.FIFO_DOUT  = {$urandom, $urandom};
      bus.FIFO_EMPTY = ($urandom_range(7) == 0);
      bus.UNDER_CLR  = ($urandom_range(39) == 0);
      if ($urandom_range(99) == 0) bus.DISPON = ~bus.DISPON;
      if ($urandom_range(499) == 0) bus.RESOL = 2'($urandom);
      tick();
    end

    bus.DISPON     = 1'b1;
    bus.FIFO_EMPTY = 1'b0;
    bus.UNDER_CLR  = 1'b0;
    measure_line(per, lw, dec);
    chk("h_period_midframe_resol", per, 800);

    // Asynchronous reset in the middle of active video.
    wait_h(300);
    chk("pre_reset_de", bus.DSP_DE, 1);
    DRST = 1'b1;
    #1;
    chk("async_rst_de", bus.DSP_DE, 0);
    chk("async_rst_rden", bus.FIFO_RDEN, 0);
    chk("async_rst_rgb", {bus.DSP_R, bus.DSP_G, bus.DSP_B}, 24'h000000);
    chk("async_rst_hsync_x", bus.DSP_HSYNC_X, 1);
    chk("async_rst_vsync_x", bus.DSP_VSYNC_X, 1);
    chk("async_rst_under", bus.DSP_FIFO_UNDER, 0);
    tick();
    tick();
    DRST = 1'b0;
    #1;
    chk("restart_rden", bus.FIFO_RDEN, 1);
    first_de(n);
    chk("restart_first_de", n, 2);
    measure_line(per, lw, dec);
    chk("restart_h_period", per, 800);
    chk("restart_de_per_line", dec, 640);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
